// File: rtl/memory_writeback_stage.sv
// Memory/writeback pipeline stage.
// ALU results retire one cycle after acceptance. Loads and stores are latched,
// and the stage holds in ACCESS with the upstream register stalled until the
// data memory acknowledges. If no acknowledge arrives within TIMEOUT cycles,
// the access is aborted and a sticky error flag is set.
module memory_writeback_stage #(
   parameter int TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wbs_in,
   input  logic        wme_in,
   input  logic        mm_in,
   input  logic        ni_in,
   input  logic [3:0]  rd_in,
   input  logic [15:0] alu_result_in,
   input  logic [15:0] mem_data_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [15:0] dmem_rdata,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   output logic        err,
   output logic [15:0] retire_count
);

   // The counter must be able to hold the value TIMEOUT itself.
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic            r_lat_wme;
   logic            r_lat_wbs;
   logic [3:0]      r_lat_rd;
   logic [15:0]     r_lat_addr;
   logic [15:0]     r_lat_data;
   logic [CW-1:0]   r_count;

   logic            r_rf_we;
   logic [3:0]      r_rf_waddr;
   logic [15:0]     r_rf_wdata;
   logic            r_err;
   logic [15:0]     r_retire;

   logic            w_idle;
   logic            w_access;
   logic            w_accept;
   logic            w_is_mem;
   logic            w_alu_accept;
   logic            w_mem_accept;
   logic            w_ack;
   logic            w_timeout;

   // Classify the incoming op and detect completion / abort of an access.
   always_comb begin
      w_idle       = (r_state == ST_IDLE);
      w_access     = (r_state == ST_ACCESS);
      w_accept     = w_idle & ~ni_in;
      w_is_mem     = wme_in | mm_in;
      w_alu_accept = w_accept & ~w_is_mem;
      w_mem_accept = w_accept & w_is_mem;
      w_ack        = w_access & dmem_ack;
      // An acknowledge in the final allowed cycle still completes normally.
      w_timeout    = w_access & ~dmem_ack & (r_count == CW'(TIMEOUT));
   end

   // Next-state logic for the IDLE/ACCESS controller.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_mem_accept) begin
               w_state_nxt = ST_ACCESS;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (w_ack || w_timeout) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_ACCESS;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Latch the memory op on acceptance and count the cycles spent in ACCESS.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lat_wme  <= 1'b0;
         r_lat_wbs  <= 1'b0;
         r_lat_rd   <= 4'd0;
         r_lat_addr <= 16'd0;
         r_lat_data <= 16'd0;
         r_count    <= CW'(0);
      end else if (w_mem_accept) begin
         r_lat_wme  <= wme_in;
         r_lat_wbs  <= wbs_in;
         r_lat_rd   <= rd_in;
         r_lat_addr <= alu_result_in;
         r_lat_data <= mem_data_in;
         r_count    <= CW'(1);
      end else if (w_access && !w_ack && !w_timeout) begin
         r_count    <= r_count + CW'(1);
      end
   end

   // Register-file write port: one-cycle pulse, address/data hold between writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= 4'd0;
         r_rf_wdata <= 16'd0;
      end else begin
         r_rf_we <= 1'b0;
         if (w_alu_accept) begin
            r_rf_we <= wbs_in;
            if (wbs_in) begin
               r_rf_waddr <= rd_in;
               r_rf_wdata <= alu_result_in;
            end
         end else if (w_ack && !r_lat_wme) begin
            // Only loads write back; a completed store leaves the port idle.
            r_rf_we <= r_lat_wbs;
            if (r_lat_wbs) begin
               r_rf_waddr <= r_lat_rd;
               r_rf_wdata <= dmem_rdata;
            end
         end
      end
   end

   // Sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_timeout) begin
         r_err <= 1'b1;
      end
   end

   // Retired-instruction counter; aborted accesses do not retire.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_retire <= 16'd0;
      end else if (w_alu_accept || w_ack) begin
         r_retire <= r_retire + 16'd1;
      end
   end

   assign stall_out    = w_access;
   assign dmem_req     = w_access;
   assign dmem_we      = w_access & r_lat_wme;
   assign dmem_addr    = r_lat_addr;
   assign dmem_wdata   = r_lat_data;
   assign rf_we        = r_rf_we;
   assign rf_waddr     = r_rf_waddr;
   assign rf_wdata     = r_rf_wdata;
   assign err          = r_err;
   assign retire_count = r_retire;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Directed bench for memory_writeback_stage. Expected register-file writes are
// queued by the stimulus; a monitor pops and compares on every rf_we pulse.
module tb_memory_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        wbs_in, wme_in, mm_in, ni_in;
   logic [3:0]  rd_in;
   logic [15:0] alu_result_in, mem_data_in;
   logic        stall_out, dmem_req, dmem_we;
   logic [15:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        err;
   logic [15:0] retire_count;

   int n_vec = 0;
   int n_err = 0;
   logic [19:0] sb[$];

   memory_writeback_stage #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in), .ni_in(ni_in),
      .rd_in(rd_in), .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
      .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .err(err), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   // Monitor: every rf_we pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL rf_write_unexpected: got waddr=%0d wdata=%h, none expected", rf_waddr, rf_wdata);
         end else begin
            logic [19:0] e;
            e = sb.pop_front();
            if ({rf_waddr, rf_wdata} !== e) begin
               n_err++;
               $display("FAIL rf_write: got waddr=%0d wdata=%h, expected waddr=%0d wdata=%h",
                        rf_waddr, rf_wdata, e[19:16], e[15:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic op(input logic wbs, input logic wme, input logic mm,
                     input logic [3:0] rd, input logic [15:0] addr, input logic [15:0] data);
      ni_in = 1'b0; wbs_in = wbs; wme_in = wme; mm_in = mm;
      rd_in = rd; alu_result_in = addr; mem_data_in = data;
   endtask

   initial begin
      rst = 1'b1; ni_in = 1'b1; wbs_in = 1'b0; wme_in = 1'b0; mm_in = 1'b0;
      rd_in = 4'd0; alu_result_in = 16'd0; mem_data_in = 16'd0;
      dmem_ack = 1'b0; dmem_rdata = 16'd0;
      tick(); tick();
      rst = 1'b0;
      settle();
      chk("rst_stall", {31'd0, stall_out}, 32'd0);
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_we", {31'd0, dmem_we}, 32'd0);
      chk("rst_addr", {16'd0, dmem_addr}, 32'd0);
      chk("rst_wdata", {16'd0, dmem_wdata}, 32'd0);
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_rf_waddr", {28'd0, rf_waddr}, 32'd0);
      chk("rst_rf_wdata", {16'd0, rf_wdata}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_retire", {16'd0, retire_count}, 32'd0);
      tick();

      // ALU op: writes back one cycle after acceptance, never stalls.
      op(1'b1, 1'b0, 1'b0, 4'd3, 16'h0005, 16'h0000);
      sb.push_back({4'd3, 16'h0005});
      settle(); chk("alu_stall_t", {31'd0, stall_out}, 32'd0);
      tick(); ni_in = 1'b1;
      settle(); chk("alu_stall_t1", {31'd0, stall_out}, 32'd0);
      chk("alu_rf_we_t1", {31'd0, rf_we}, 32'd1);
      tick();
      settle(); chk("alu_rf_we_t2", {31'd0, rf_we}, 32'd0);
      chk("alu_retire", {16'd0, retire_count}, 32'd1);
      chk("alu_waddr_hold", {28'd0, rf_waddr}, 32'd3);
      tick();

      // Load acknowledged on the third ACCESS cycle.
      op(1'b1, 1'b0, 1'b1, 4'd7, 16'h0010, 16'h0000);
      tick(); ni_in = 1'b1;
      settle(); chk("ld_stall_t1", {31'd0, stall_out}, 32'd1);
      chk("ld_req_t1", {31'd0, dmem_req}, 32'd1);
      chk("ld_addr_t1", {16'd0, dmem_addr}, 32'h0010);
      chk("ld_we_t1", {31'd0, dmem_we}, 32'd0);
      tick();
      settle(); chk("ld_req_t2", {31'd0, dmem_req}, 32'd1);
      tick(); dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
      sb.push_back({4'd7, 16'hBEEF});
      settle(); chk("ld_req_t3", {31'd0, dmem_req}, 32'd1);
      chk("ld_stall_t3", {31'd0, stall_out}, 32'd1);
      tick(); dmem_ack = 1'b0; dmem_rdata = 16'h0000;
      settle(); chk("ld_req_t4", {31'd0, dmem_req}, 32'd0);
      chk("ld_stall_t4", {31'd0, stall_out}, 32'd0);
      chk("ld_rf_wdata", {16'd0, rf_wdata}, 32'hBEEF);
      chk("ld_retire", {16'd0, retire_count}, 32'd2);
      tick();

      // Store with mm_in also set: store wins, no register write.
      op(1'b1, 1'b1, 1'b1, 4'd4, 16'h0020, 16'h1234);
      tick(); ni_in = 1'b1; dmem_ack = 1'b1;
      settle(); chk("st_we", {31'd0, dmem_we}, 32'd1);
      chk("st_wdata", {16'd0, dmem_wdata}, 32'h1234);
      chk("st_addr", {16'd0, dmem_addr}, 32'h0020);
      chk("st_req", {31'd0, dmem_req}, 32'd1);
      tick(); dmem_ack = 1'b0;
      settle(); chk("st_req_done", {31'd0, dmem_req}, 32'd0);
      chk("st_retire", {16'd0, retire_count}, 32'd3);
      tick();

      // Acknowledge while IDLE is ignored.
      dmem_ack = 1'b1;
      tick(); dmem_ack = 1'b0;
      settle(); chk("idle_ack_stall", {31'd0, stall_out}, 32'd0);
      chk("idle_ack_retire", {16'd0, retire_count}, 32'd3);
      tick();

      // Bubble with live-looking fields changes nothing.
      wbs_in = 1'b1; mm_in = 1'b1; rd_in = 4'd2; alu_result_in = 16'h0077; ni_in = 1'b1;
      tick();
      settle(); chk("bubble_retire", {16'd0, retire_count}, 32'd3);
      chk("bubble_wdata", {16'd0, rf_wdata}, 32'hBEEF);
      chk("bubble_stall", {31'd0, stall_out}, 32'd0);
      tick();

      // Load that never gets acknowledged: aborts after 8 ACCESS cycles.
      op(1'b1, 1'b0, 1'b1, 4'd5, 16'h0030, 16'h0000);
      tick(); ni_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         settle(); chk($sformatf("to_req_t%0d", i), {31'd0, dmem_req}, 32'd1);
         tick();
      end
      settle(); chk("to_stall_t9", {31'd0, stall_out}, 32'd0);
      chk("to_req_t9", {31'd0, dmem_req}, 32'd0);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_retire", {16'd0, retire_count}, 32'd3);
      tick();
      settle(); chk("to_err_sticky", {31'd0, err}, 32'd1);
      tick();

      // Reset clears the error; rerun with ack in the last allowed cycle.
      rst = 1'b1;
      tick(); rst = 1'b0;
      settle(); chk("rst2_err", {31'd0, err}, 32'd0);
      chk("rst2_retire", {16'd0, retire_count}, 32'd0);
      tick();
      op(1'b1, 1'b0, 1'b1, 4'd9, 16'h0040, 16'h0000);
      tick(); ni_in = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         settle(); chk($sformatf("ack8_req_t%0d", i), {31'd0, dmem_req}, 32'd1);
         tick();
      end
      dmem_ack = 1'b1; dmem_rdata = 16'hCAFE;
      sb.push_back({4'd9, 16'hCAFE});
      settle(); chk("ack8_req_t8", {31'd0, dmem_req}, 32'd1);
      tick(); dmem_ack = 1'b0;
      settle(); chk("ack8_err", {31'd0, err}, 32'd0);
      chk("ack8_stall", {31'd0, stall_out}, 32'd0);
      chk("ack8_retire", {16'd0, retire_count}, 32'd1);
      tick();

      // Reset in the middle of a pending load discards it.
      op(1'b1, 1'b0, 1'b1, 4'd10, 16'h0050, 16'h0000);
      tick(); ni_in = 1'b1;
      tick(); rst = 1'b1;
      settle(); chk("rstacc_req_t2", {31'd0, dmem_req}, 32'd1);
      tick(); rst = 1'b0;
      settle(); chk("rstacc_req_t3", {31'd0, dmem_req}, 32'd0);
      chk("rstacc_stall_t3", {31'd0, stall_out}, 32'd0);
      chk("rstacc_retire", {16'd0, retire_count}, 32'd0);
      tick(); tick();

      // Retire counter wrap: 65535 ALU ops without writeback, then one more.
      op(1'b0, 1'b0, 1'b0, 4'd1, 16'h0001, 16'h0000);
      repeat (65535) tick();
      ni_in = 1'b1;
      settle(); chk("wrap_ffff", {16'd0, retire_count}, 32'h0000FFFF);
      tick();
      ni_in = 1'b0;
      tick(); ni_in = 1'b1;
      settle(); chk("wrap_zero", {16'd0, retire_count}, 32'd0);
      tick();

      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/memory_writeback_stage.md
MEMORY_WRITEBACK_STAGE -- requirements
Module: memory_writeback_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, meaning the maximum ACCESS cycles to wait for dmem_ack before aborting.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports wbs_in / wme_in / mm_in, input, 1 each: register-writeback enable / memory-write enable / memory-to-register select.
REQ-005 SHALL have port ni_in, input, 1: bubble marker; 1 = no instruction.
REQ-006 SHALL have port rd_in, input, 4: destination register.
REQ-007 SHALL have ports alu_result_in / mem_data_in, input, 16 each: address-or-result / store data.
REQ-008 SHALL have port stall_out, output, 1: upstream ExecuteMemory register holds while 1.
REQ-009 SHALL have ports dmem_req / dmem_we, output, 1 each, and dmem_addr / dmem_wdata, output, 16 each.
REQ-010 SHALL have ports dmem_ack, input, 1, and dmem_rdata, input, 16.
REQ-011 SHALL have ports rf_we, output, 1; rf_waddr, output, 4; rf_wdata, output, 16.
REQ-012 SHALL have ports err, output, 1 (sticky timeout flag), and retire_count, output, 16.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, ACCESS.
REQ-014 SHALL sample inputs only in IDLE; inputs ignored in ACCESS.
REQ-015 SHALL treat ni_in=1 as a bubble: no state change, no rf write, no count.
REQ-016 SHALL classify op: store if wme_in=1 (wins over mm_in); load if mm_in=1 and wme_in=0; ALU otherwise.
REQ-017 ALU op accepted at cycle t SHALL give rf_we=wbs_in, rf_waddr=rd_in, rf_wdata=alu_result_in at t+1; FSM stays IDLE.
REQ-018 Load/store accepted at t SHALL latch op and enter ACCESS at t+1.
REQ-019 In ACCESS SHALL drive dmem_req=1, dmem_addr=latched alu_result, dmem_we=latched wme, dmem_wdata=latched mem_data, all held stable.
REQ-020 stall_out SHALL equal (state==ACCESS), combinational from state.
REQ-021 dmem_ack=1 in ACCESS at cycle a SHALL return to IDLE at a+1; load gives rf_we=latched wbs, rf_wdata=dmem_rdata sampled at a, at a+1.
REQ-022 Store SHALL never assert rf_we.
REQ-023 rf_we SHALL be a one-cycle pulse; outside it rf_waddr/rf_wdata hold last value.
REQ-024 SHALL count ACCESS cycles starting at 1 on entry; count==TIMEOUT with dmem_ack=0 SHALL abort to IDLE, set err=1, suppress rf write.
REQ-025 dmem_ack coincident with count==TIMEOUT SHALL complete normally (ack wins).
REQ-026 dmem_ack in IDLE SHALL be ignored.
REQ-027 retire_count SHALL increment by 1 per completed non-bubble op (ALU at acceptance, mem on ack), wrapping 0xFFFF->0x0000; aborted ops not counted.
REQ-028 err SHALL remain 1 until rst.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, stall_out=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, rf_we=0, rf_waddr=0, rf_wdata=0, err=0, retire_count=0.
REQ-030 rst during ACCESS SHALL drop dmem_req the next cycle and discard the pending op with no rf write.

Verification
REQ-031 ALU op wbs=1, rd=3, alu_result=0x0005 at t -> rf_we=1, rf_waddr=3, rf_wdata=0x0005 at t+1 only; stall_out=0 throughout; retire_count=1.
REQ-032 Load mm=1, rd=7, addr=0x0010; dmem_ack at t+3 with rdata=0xBEEF -> dmem_req=1 t+1..t+3, stall_out=1 t+1..t+3, rf_we=1 rf_wdata=0xBEEF at t+4.
REQ-033 Store wme=1, mm=1, wbs=1, addr=0x0020, data=0x1234, ack at t+1 -> dmem_we=1, dmem_wdata=0x1234 at t+1; rf_we never 1.
REQ-034 Load with no ack, TIMEOUT=8 -> dmem_req=1 t+1..t+8, IDLE at t+9, err=1, no rf write; ack at exactly t+8 in rerun -> normal completion, err=0.
REQ-035 rst asserted at t+2 of a pending load -> dmem_req=0, stall_out=0 at t+3, no rf write; ni_in=1 op -> no outputs change.
REQ-036 retire_count preloaded to 0xFFFF via 65535 ALU ops, one more -> 0x0000.
